// File: rtl/vfpu_job_sequencer.sv
// Per-job sequencer for the vector FPU: starts the source/sink streamers, meters
// operand issue against the FPU pipeline credit and reports job completion.
module vfpu_job_sequencer #(
    parameter int NB_OPERANDS  = 2,
    parameter int CNT_WIDTH    = 16,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   start_i,
    input  logic [CNT_WIDTH-1:0]   n_elems_i,
    input  logic [NB_OPERANDS-1:0] src_ready_start_i,
    input  logic                   sink_ready_start_i,
    input  logic                   sink_done_i,
    output logic [NB_OPERANDS-1:0] src_req_start_o,
    output logic                   sink_req_start_o,
    input  logic                   issue_valid_i,
    output logic                   issue_ready_o,
    input  logic                   fpu_ready_i,
    input  logic                   res_valid_i,
    input  logic                   res_ready_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [2:0]             state_dbg_o
);

    localparam int IW = $clog2(MAX_INFLIGHT + 1);

    // Handshakes: a transfer happens on a rising clock edge where valid and
    // ready are both high; ready never depends on valid in this block.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] n_q, issued_q, results_q;
    logic [IW-1:0]        inflight_q;

    logic job_accept;
    logic all_ready;
    logic issue_fire;
    logic issue_last;
    logic res_fire;
    logic res_count;
    logic results_done;

    assign job_accept = (state_q == IDLE) && start_i;
    assign all_ready  = (&src_ready_start_i) && sink_ready_start_i;

    assign issue_ready_o = (state_q == RUN) && fpu_ready_i &&
                           (inflight_q < IW'(MAX_INFLIGHT)) && (issued_q < n_q);
    assign issue_fire    = issue_valid_i && issue_ready_o;
    assign issue_last    = issue_fire && ((issued_q + CNT_WIDTH'(1)) == n_q);

    assign res_fire  = res_valid_i && res_ready_i && ((state_q == RUN) || (state_q == DRAIN));
    assign res_count = res_fire && (results_q != n_q);
    // Looks one result ahead so completion is seen in the cycle of the last result.
    assign results_done = (results_q == n_q) ||
                          (res_count && ((results_q + CNT_WIDTH'(1)) == n_q));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = (n_elems_i == '0) ? DONE : START;
            START:   if (all_ready) state_d = RUN;
            RUN:     if (issue_last) state_d = DRAIN;
            DRAIN:   if (results_done && sink_done_i) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign src_req_start_o  = (state_q == START) ? '1 : '0;
    assign sink_req_start_o = (state_q == START);
    assign busy_o           = (state_q != IDLE);
    assign done_o           = (state_q == DONE);
    assign state_dbg_o      = state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else if (clear_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            n_q        <= '0;
            issued_q   <= '0;
            results_q  <= '0;
            inflight_q <= '0;
        end else if (clear_i) begin
            n_q        <= '0;
            issued_q   <= '0;
            results_q  <= '0;
            inflight_q <= '0;
        end else if (job_accept) begin
            n_q        <= n_elems_i;
            issued_q   <= '0;
            results_q  <= '0;
            inflight_q <= '0;
        end else begin
            if (issue_fire) issued_q <= issued_q + CNT_WIDTH'(1);
            if (res_count) results_q <= results_q + CNT_WIDTH'(1);
            // A result with nothing in flight is a protocol error; hold at zero.
            if (issue_fire && !res_fire) begin
                inflight_q <= inflight_q + IW'(1);
            end else if (!issue_fire && res_fire && (inflight_q != '0)) begin
                inflight_q <= inflight_q - IW'(1);
            end
        end
    end

    res_underflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(res_fire && !clear_i && (inflight_q == '0)));

endmodule

// File: tb/tb_vfpu_job_sequencer.sv
// Directed bench for vfpu_job_sequencer: a small FPU latency model feeds results
// back and each job's counts and timing are checked against hand-derived values.
module tb_vfpu_job_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear_i = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] n_elems_i = '0;
    logic [1:0]  src_ready_start_i = '0;
    logic        sink_ready_start_i = 1'b0;
    logic        sink_done_i = 1'b0;
    logic [1:0]  src_req_start_o;
    logic        sink_req_start_o;
    logic        issue_valid_i = 1'b0;
    logic        issue_ready_o;
    logic        fpu_ready_i = 1'b0;
    logic        res_valid_i = 1'b0;
    logic        res_ready_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic [2:0]  state_dbg_o;

    int n_checks = 0;
    int n_errors = 0;

    vfpu_job_sequencer #(
        .NB_OPERANDS(2), .CNT_WIDTH(16), .MAX_INFLIGHT(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
        .n_elems_i(n_elems_i), .src_ready_start_i(src_ready_start_i),
        .sink_ready_start_i(sink_ready_start_i), .sink_done_i(sink_done_i),
        .src_req_start_o(src_req_start_o), .sink_req_start_o(sink_req_start_o),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .fpu_ready_i(fpu_ready_i), .res_valid_i(res_valid_i), .res_ready_i(res_ready_i),
        .busy_o(busy_o), .done_o(done_o), .state_dbg_o(state_dbg_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_idle();
        clear_i = 0; start_i = 0; n_elems_i = '0;
        src_ready_start_i = '0; sink_ready_start_i = 0; sink_done_i = 0;
        issue_valid_i = 0; fpu_ready_i = 0; res_valid_i = 0; res_ready_i = 0;
    endtask

    // One job from the start pulse at cycle 0. FPU answers lat cycles after an
    // issue; src_ready_start_i[1] stays low for hold cycles of START.
    // abort_mode 1: clear_i once abort_at issues are done; 2: async reset in DRAIN.
    task automatic run_job(input int n, input int lat, input int hold, input bit mid_start,
                           input int abort_mode, input int abort_at,
                           output int n_issue, output int n_res, output int max_infl,
                           output int req_cyc, output int first_rdy, output int busy_low,
                           output int done_lag, output int sd_lead,
                           output bit timed_out, output bit aborted);
        int due_q[$];
        int infl, last_acc, sd_first, done_cyc;
        bit fire, acc;
        n_issue = 0; n_res = 0; max_infl = 0; req_cyc = 0; first_rdy = -1;
        busy_low = 0; done_lag = -1; sd_lead = -1; timed_out = 1; aborted = 0;
        infl = 0; last_acc = -1; sd_first = -1; done_cyc = -1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            start_i            = (cyc == 0) || (mid_start && cyc == hold + 4);
            n_elems_i          = (cyc == 0) ? 16'(n) : 16'd3;
            src_ready_start_i  = {(cyc >= hold + 1), 1'b1};
            sink_ready_start_i = 1;
            issue_valid_i      = 1;
            fpu_ready_i        = 1;
            res_valid_i        = (due_q.size() > 0) && (due_q[0] <= cyc);
            res_ready_i        = 1;
            sink_done_i        = (n_issue == n);
            clear_i            = (abort_mode == 1) && (n_issue == abort_at);
            #1;
            if (abort_mode == 2 && n_issue == n) begin
                check_eq("drain_before_reset", state_dbg_o, 3);
                rst_ni = 0;
                #1;
                aborted = 1; timed_out = 0;
                break;
            end
            if (src_req_start_o != 2'b00 || sink_req_start_o) req_cyc++;
            if (cyc >= 1 && !busy_o) busy_low++;
            if (issue_ready_o && first_rdy < 0) first_rdy = cyc;
            if (done_o) begin
                done_cyc = cyc; done_lag = done_cyc - last_acc;
                sd_lead = last_acc - sd_first; timed_out = 0;
                break;
            end
            fire = issue_valid_i && issue_ready_o;
            acc  = res_valid_i && res_ready_i;
            if (fire) begin due_q.push_back(cyc + lat); n_issue++; infl++; end
            if (acc) begin void'(due_q.pop_front()); n_res++; infl--; last_acc = cyc; end
            if (infl > max_infl) max_infl = infl;
            if (sink_done_i && sd_first < 0) sd_first = cyc;
            if (clear_i) begin
                step();
                clear_i = 0; aborted = 1; timed_out = 0;
                break;
            end
            step();
        end
    endtask

    int  n_issue, n_res, max_infl, req_cyc, first_rdy, busy_low, done_lag, sd_lead;
    bit  timed_out, aborted;
    int  done_seen;

    task automatic check_done_tail(input string tag);
        step();
        drive_idle();
        #1;
        check_eq({tag, "_done_one_cycle"}, done_o, 0);
        check_eq({tag, "_idle_after_done"}, busy_o, 0);
    endtask

    initial begin
        drive_idle();
        issue_valid_i = 1; fpu_ready_i = 1;
        repeat (3) step();
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_src_req", src_req_start_o, 0);
        check_eq("rst_sink_req", sink_req_start_o, 0);
        check_eq("rst_issue_ready", issue_ready_o, 0);
        check_eq("rst_state", state_dbg_o, 0);
        @(negedge clk_i);
        rst_ni = 1;
        drive_idle();
        step();

        // n=8, everything ready, single-cycle FPU
        run_job(8, 1, 0, 0, 0, 0, n_issue, n_res, max_infl, req_cyc, first_rdy,
                busy_low, done_lag, sd_lead, timed_out, aborted);
        check_eq("t1_timeout", timed_out, 0);
        check_eq("t1_issues", n_issue, 8);
        check_eq("t1_results", n_res, 8);
        check_eq("t1_req_cycles", req_cyc, 1);
        check_eq("t1_first_ready", first_rdy, 2);
        check_eq("t1_busy_low", busy_low, 0);
        check_eq("t1_done_lag", done_lag, 1);
        check_eq("t1_max_inflight", max_infl, 1);
        check_done_tail("t1");

        // n=10, FPU latency 6: credit of 4 must throttle issue
        run_job(10, 6, 0, 0, 0, 0, n_issue, n_res, max_infl, req_cyc, first_rdy,
                busy_low, done_lag, sd_lead, timed_out, aborted);
        check_eq("t2_timeout", timed_out, 0);
        check_eq("t2_issues", n_issue, 10);
        check_eq("t2_results", n_res, 10);
        check_eq("t2_max_inflight", max_infl, 4);
        check_eq("t2_done_lag", done_lag, 1);
        check_done_tail("t2");

        // n=0: straight to DONE, no streamer starts
        step();
        start_i = 1; n_elems_i = 16'd0;
        src_ready_start_i = 2'b11; sink_ready_start_i = 1;
        #1;
        check_eq("t3_idle_busy", busy_o, 0);
        step();
        start_i = 0;
        #1;
        check_eq("t3_done", done_o, 1);
        check_eq("t3_busy", busy_o, 1);
        check_eq("t3_src_req", src_req_start_o, 0);
        check_eq("t3_sink_req", sink_req_start_o, 0);
        check_done_tail("t3");

        // source 1 late by 5 cycles: req_start held, no issue before RUN
        run_job(4, 1, 5, 0, 0, 0, n_issue, n_res, max_infl, req_cyc, first_rdy,
                busy_low, done_lag, sd_lead, timed_out, aborted);
        check_eq("t4_timeout", timed_out, 0);
        check_eq("t4_req_cycles", req_cyc, 6);
        check_eq("t4_first_ready", first_rdy, 7);
        check_eq("t4_issues", n_issue, 4);
        check_eq("t4_done_lag", done_lag, 1);
        check_done_tail("t4");

        // sink_done_i early, second start mid-RUN ignored
        run_job(10, 6, 0, 1, 0, 0, n_issue, n_res, max_infl, req_cyc, first_rdy,
                busy_low, done_lag, sd_lead, timed_out, aborted);
        check_eq("t5_timeout", timed_out, 0);
        check_eq("t5_issues", n_issue, 10);
        check_eq("t5_results", n_res, 10);
        check_eq("t5_sink_done_lead", sd_lead, 5);
        check_eq("t5_done_lag", done_lag, 1);
        check_done_tail("t5");
        step();
        check_eq("t5_no_queued_start", busy_o, 0);

        // clear_i after 3 of 8 issues
        run_job(8, 1, 0, 0, 1, 3, n_issue, n_res, max_infl, req_cyc, first_rdy,
                busy_low, done_lag, sd_lead, timed_out, aborted);
        check_eq("t6_clear_reached", aborted, 1);
        check_eq("t6_clear_state", state_dbg_o, 0);
        check_eq("t6_clear_busy", busy_o, 0);
        check_eq("t6_clear_issue_ready", issue_ready_o, 0);
        done_seen = 0;
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            if (done_o) done_seen++;
            step();
        end
        check_eq("t6_clear_no_done", done_seen, 0);
        run_job(2, 1, 0, 0, 0, 0, n_issue, n_res, max_infl, req_cyc, first_rdy,
                busy_low, done_lag, sd_lead, timed_out, aborted);
        check_eq("t6_after_clear_timeout", timed_out, 0);
        check_eq("t6_after_clear_issues", n_issue, 2);
        check_eq("t6_after_clear_done_lag", done_lag, 1);
        check_done_tail("t6c");

        // async reset in DRAIN
        run_job(4, 6, 0, 0, 2, 0, n_issue, n_res, max_infl, req_cyc, first_rdy,
                busy_low, done_lag, sd_lead, timed_out, aborted);
        check_eq("t6_rst_reached", aborted, 1);
        check_eq("t6_rst_state", state_dbg_o, 0);
        check_eq("t6_rst_busy", busy_o, 0);
        check_eq("t6_rst_done", done_o, 0);
        check_eq("t6_rst_issue_ready", issue_ready_o, 0);
        drive_idle();
        #2;
        rst_ni = 1;
        step();
        run_job(2, 1, 0, 0, 0, 0, n_issue, n_res, max_infl, req_cyc, first_rdy,
                busy_low, done_lag, sd_lead, timed_out, aborted);
        check_eq("t6_after_rst_timeout", timed_out, 0);
        check_eq("t6_after_rst_issues", n_issue, 2);
        check_eq("t6_after_rst_results", n_res, 2);
        check_eq("t6_after_rst_done_lag", done_lag, 1);
        check_done_tail("t6r");

        // final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
